// File: rtl/uart_rx_oversampler.sv
// 8N1 UART receiver running on sysclk, sampling off a 16x oversampling baud clock.
// brclk is edge-detected into a one-cycle tick; all FSM activity happens only on ticks.
module uart_rx_oversampler #(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 sysclk,
  input  logic                 reset,
  input  logic                 brclk,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] C_MID  = CW'(OVERSAMPLE / 2 - 2);
  localparam logic [CW-1:0] C_END  = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t                 r_state, w_nx_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_brclk_d;
  logic [CW-1:0]          r_cnt, w_nx_cnt;
  logic [BW-1:0]          r_bit_idx, w_nx_bit;
  logic [DATA_BITS-1:0]   r_shift, w_nx_shift;
  logic [DATA_BITS-1:0]   r_data, w_nx_data;
  logic                   r_valid, w_nx_valid;
  logic                   r_ferr, w_nx_ferr;
  logic                   w_tick, w_rx_s;

  assign w_tick    = brclk & ~r_brclk_d;
  assign w_rx_s    = r_sync[SYNC_STAGES-1];
  assign rx_data   = r_data;
  assign rx_valid  = r_valid;
  assign frame_err = r_ferr;
  assign busy      = (r_state != S_IDLE);

  // Sync chain presets to idle-high so reset never looks like a start bit.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      r_sync    <= '1;
      r_brclk_d <= 1'b0;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], rx};
      r_brclk_d <= brclk;
    end
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_state   <= w_nx_state;
      r_cnt     <= w_nx_cnt;
      r_bit_idx <= w_nx_bit;
      r_shift   <= w_nx_shift;
      r_data    <= w_nx_data;
      r_valid   <= w_nx_valid;
      r_ferr    <= w_nx_ferr;
    end
  end

  always_comb begin
    w_nx_state = r_state;
    w_nx_cnt   = r_cnt;
    w_nx_bit   = r_bit_idx;
    w_nx_shift = r_shift;
    w_nx_data  = r_data;
    w_nx_valid = 1'b0;
    w_nx_ferr  = 1'b0;
    if (w_tick) begin
      unique case (r_state)
        S_IDLE: begin
          if (!w_rx_s) begin
            w_nx_state = S_START;
            w_nx_cnt   = '0;
          end
        end
        S_START: begin
          // Re-check the line near mid start bit to reject short glitches.
          if (r_cnt == C_MID) begin
            w_nx_cnt   = '0;
            w_nx_bit   = '0;
            w_nx_state = w_rx_s ? S_IDLE : S_DATA;
          end else begin
            w_nx_cnt = r_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (r_cnt == C_END) begin
            w_nx_shift = {w_rx_s, r_shift[DATA_BITS-1:1]};
            w_nx_cnt   = '0;
            w_nx_bit   = r_bit_idx + BW'(1);
            if (r_bit_idx == B_LAST) w_nx_state = S_STOP;
          end else begin
            w_nx_cnt = r_cnt + CW'(1);
          end
        end
        S_STOP: begin
          // Leave at mid stop bit so a following start edge is caught immediately.
          if (r_cnt == C_END) begin
            if (w_rx_s) begin
              w_nx_data  = r_shift;
              w_nx_valid = 1'b1;
            end else begin
              w_nx_ferr  = 1'b1;
            end
            w_nx_state = S_IDLE;
            w_nx_cnt   = '0;
          end else begin
            w_nx_cnt = r_cnt + CW'(1);
          end
        end
        default: w_nx_state = S_IDLE;
      endcase
    end
  end
endmodule
